round_sequencer: RTL and testbench

- Top-level game controller for the symbol-counting game.
- Runs NUM_ROUNDS rounds. Each round has three phases:
  - Display phase: symbols are shown for a timed window.
  - Guess phase: the player's button presses are counted.
  - Scoring phase: the score block is sequenced through start, then settle, then stop, and its 5-bit difference is captured.
- Per-round differences are accumulated into a saturating total penalty, and completion is reported.
- Sits between the button conditioning logic and the score comparator. It drives the score comparator's start/stop and userCount inputs.

---
 rtl/round_pkg.sv | 31 +++
 rtl/tick_gen.sv | 36 +++
 rtl/round_sequencer.sv | 178 +++++++++++++++++
 tb/tb_round_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/round_pkg.sv
`default_nettype none
// ============================================================================
// Module      : round_pkg
// Description : Shared state encoding, limits and penalty saturation helper
//               for the symbol-counting game sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package round_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHOW  = 3'd1,
        GUESS = 3'd2,
        SCORE = 3'd3,
        LATCH = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [7:0] USER_CNT_MAX = 8'd255;
    localparam logic [9:0] PENALTY_MAX  = 10'd1023;

    // Clamp an 11-bit running sum back into the 10-bit penalty range.
    function automatic logic [9:0] sat_penalty(input logic [10:0] sum);
        if (sum > {1'b0, PENALTY_MAX}) begin
            return PENALTY_MAX;
        end
        return sum[9:0];
    endfunction

endpackage : round_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Millisecond prescaler; pulses tick on the cycle the counter
//               wraps and restarts from zero whenever clr is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic Clk100M,
    input  logic Rst_n,
    input  logic clr,
    output logic tick
);

    localparam int                 c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_WRAP  = c_CNT_W'(TICK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == c_WRAP)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Not masked by clr: the sequencer derives clr from tick on phase exit.
    assign tick = (r_cnt == c_WRAP);

endmodule : tick_gen
`default_nettype wire

// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : round_sequencer
// Description : Game controller: runs NUM_ROUNDS show/guess/score rounds,
//               drives the score comparator and accumulates the penalty.
// Revision    : 1.0 - initial release
// ============================================================================
module round_sequencer
    import round_pkg::*;
#(
    parameter int TICK_DIV   = 100000,
    parameter int SHOW_MS    = 3000,
    parameter int GUESS_MS   = 10000,
    parameter int NUM_ROUNDS = 5,
    parameter int SETTLE     = 3
) (
    input  logic       Clk100M,
    input  logic       Rst_n,
    input  logic       go,
    input  logic       user_btn,
    input  logic       submit,
    input  logic [4:0] difference,
    output logic       show_symbols,
    output logic       score_start,
    output logic       score_stop,
    output logic [7:0] user_count,
    output logic [3:0] round,
    output logic [9:0] total_penalty,
    output logic       busy,
    output logic       done
);

    localparam int c_TMR_MAX0 = (SHOW_MS > GUESS_MS) ? SHOW_MS : GUESS_MS;
    localparam int c_TMR_MAX  = (c_TMR_MAX0 > SETTLE) ? c_TMR_MAX0 : SETTLE;
    localparam int c_TMR_W    = $clog2(c_TMR_MAX);

    localparam logic [c_TMR_W-1:0] c_SHOW_LAST   = c_TMR_W'(SHOW_MS - 1);
    localparam logic [c_TMR_W-1:0] c_GUESS_LAST  = c_TMR_W'(GUESS_MS - 1);
    localparam logic [c_TMR_W-1:0] c_SETTLE_LAST = c_TMR_W'(SETTLE - 1);
    localparam logic [3:0]         c_LAST_ROUND  = 4'(NUM_ROUNDS - 1);

    state_t             r_state;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_show_symbols;
    logic               r_score_start;
    logic               r_score_stop;
    logic [7:0]         r_user_count;
    logic [3:0]         r_round;
    logic [9:0]         r_total_penalty;
    logic               r_busy;
    logic               r_done;

    logic               w_tick;
    logic               w_advance;
    logic               w_last_round;
    logic [10:0]        w_pen_sum;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .Clk100M (Clk100M),
        .Rst_n   (Rst_n),
        .clr     (w_advance),
        .tick    (w_tick)
    );

    // w_advance marks the last cycle of the current state; it also restarts
    // the prescaler so every phase begins on a fresh tick boundary.
    always_comb begin
        w_advance = 1'b0;
        case (r_state)
            IDLE, DONE: w_advance = go;
            SHOW:       w_advance = w_tick && (r_timer == c_SHOW_LAST);
            GUESS:      w_advance = submit || (w_tick && (r_timer == c_GUESS_LAST));
            SCORE:      w_advance = (r_timer == c_SETTLE_LAST);
            LATCH:      w_advance = 1'b1;
            default:    w_advance = 1'b0;
        endcase
    end

    assign w_last_round = (r_round == c_LAST_ROUND);
    assign w_pen_sum    = {1'b0, r_total_penalty} + {6'd0, difference};

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state         <= IDLE;
            r_timer         <= '0;
            r_show_symbols  <= 1'b0;
            r_score_start   <= 1'b0;
            r_score_stop    <= 1'b0;
            r_user_count    <= '0;
            r_round         <= '0;
            r_total_penalty <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_score_start <= 1'b0;
            r_score_stop  <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_advance) begin
                        r_state         <= SHOW;
                        r_timer         <= '0;
                        r_round         <= '0;
                        r_total_penalty <= '0;
                        r_user_count    <= '0;
                        r_show_symbols  <= 1'b1;
                        r_busy          <= 1'b1;
                        r_done          <= 1'b0;
                    end
                end
                SHOW: begin
                    if (w_advance) begin
                        r_state        <= GUESS;
                        r_timer        <= '0;
                        r_show_symbols <= 1'b0;
                    end else if (w_tick) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                GUESS: begin
                    // A press in the exit cycle still counts.
                    if (user_btn && (r_user_count != USER_CNT_MAX)) begin
                        r_user_count <= r_user_count + 8'd1;
                    end
                    if (w_advance) begin
                        r_state       <= SCORE;
                        r_timer       <= '0;
                        r_score_start <= 1'b1;
                    end else if (w_tick) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                SCORE: begin
                    if (w_advance) begin
                        r_state      <= LATCH;
                        r_timer      <= '0;
                        r_score_stop <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                LATCH: begin
                    r_total_penalty <= sat_penalty(w_pen_sum);
                    r_timer         <= '0;
                    if (w_last_round) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state        <= SHOW;
                        r_round        <= r_round + 4'd1;
                        r_user_count   <= '0;
                        r_show_symbols <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_timer        <= '0;
                    r_show_symbols <= 1'b0;
                    r_busy         <= 1'b0;
                    r_done         <= 1'b0;
                end
            endcase
        end
    end

    assign show_symbols  = r_show_symbols;
    assign score_start   = r_score_start;
    assign score_stop    = r_score_stop;
    assign user_count    = r_user_count;
    assign round         = r_round;
    assign total_penalty = r_total_penalty;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule : round_sequencer
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_sequencer
// Description : Directed self-checking bench for round_sequencer with a
//               per-round expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_sequencer;

    logic       Clk100M = 1'b0;
    logic       Rst_n   = 1'b0;
    logic       go      = 1'b0;
    logic       user_btn = 1'b0;
    logic       submit  = 1'b0;
    logic [4:0] difference = 5'd0;
    logic       show_symbols, score_start, score_stop, busy, done;
    logic [7:0] user_count;
    logic [3:0] round;
    logic [9:0] total_penalty;

    logic       l_go = 1'b0, l_btn = 1'b0, l_submit = 1'b0;
    logic [4:0] l_diff = 5'd0;
    logic       l_show, l_start, l_stop, l_busy, l_done;
    logic [7:0] l_count;
    logic [3:0] l_round;
    logic [9:0] l_total;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] uc;
        logic [9:0] pen;
    } exp_t;
    exp_t sb[$];

    always #5 Clk100M = ~Clk100M;

    round_sequencer #(
        .TICK_DIV(4), .SHOW_MS(2), .GUESS_MS(5), .NUM_ROUNDS(2), .SETTLE(3)
    ) dut (
        .Clk100M(Clk100M), .Rst_n(Rst_n), .go(go), .user_btn(user_btn),
        .submit(submit), .difference(difference), .show_symbols(show_symbols),
        .score_start(score_start), .score_stop(score_stop), .user_count(user_count),
        .round(round), .total_penalty(total_penalty), .busy(busy), .done(done)
    );

    // Long guess window so a 300-cycle press burst fits in one GUESS phase.
    round_sequencer #(
        .TICK_DIV(4), .SHOW_MS(2), .GUESS_MS(80), .NUM_ROUNDS(1), .SETTLE(3)
    ) dut_long (
        .Clk100M(Clk100M), .Rst_n(Rst_n), .go(l_go), .user_btn(l_btn),
        .submit(l_submit), .difference(l_diff), .show_symbols(l_show),
        .score_start(l_start), .score_stop(l_stop), .user_count(l_count),
        .round(l_round), .total_penalty(l_total), .busy(l_busy), .done(l_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_show"},  32'(show_symbols),  0);
        check({tag, "_start"}, 32'(score_start),   0);
        check({tag, "_stop"},  32'(score_stop),    0);
        check({tag, "_ucnt"},  32'(user_count),    0);
        check({tag, "_round"}, 32'(round),         0);
        check({tag, "_pen"},   32'(total_penalty), 0);
        check({tag, "_busy"},  32'(busy),          0);
        check({tag, "_done"},  32'(done),          0);
    endtask

    // Entered on the first SHOW-cycle negedge; returns on the negedge after LATCH.
    task automatic play_round(input int presses, input int submit_at, input logic [4:0] diff,
                              input logic [7:0] exp_uc, input logic [9:0] exp_pen,
                              input int exp_guess_len);
        int   n;
        int   g;
        int   s;
        exp_t e;
        difference = diff;
        sb.push_back('{uc: exp_uc, pen: exp_pen});
        n = 0;
        while (show_symbols === 1'b1 && n < 100) begin
            n++;
            user_btn = (n == 2);
            go       = (n == 4);
            submit   = (n == 6);
            @(negedge Clk100M);
        end
        user_btn = 1'b0; go = 1'b0; submit = 1'b0;
        check("show_len", n, 8);
        g = 0;
        while (score_start !== 1'b1 && g < 100) begin
            user_btn = (g < presses);
            submit   = (g == submit_at);
            go       = (g == 1);
            g++;
            @(negedge Clk100M);
        end
        user_btn = 1'b0; go = 1'b0; submit = 1'b0;
        check("guess_len", g, exp_guess_len);
        s = 0;
        while (score_stop !== 1'b1 && s < 20) begin
            s++;
            @(negedge Clk100M);
        end
        check("stop_delay", s, 3);
        check("start_stop_excl", 32'(score_start), 0);
        e = sb.pop_front();
        check("user_count", 32'(user_count), 32'(e.uc));
        @(negedge Clk100M);
        check("penalty", 32'(total_penalty), 32'(e.pen));
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge Clk100M);
        go = 1'b0;
    endtask

    initial begin
        int k;
        repeat (3) @(negedge Clk100M);
        check_all_zero("reset");
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk100M);

        // Game 1: timeout round with 3 presses, then early-submit round.
        pulse_go();
        check("go_latency_show", 32'(show_symbols), 1);
        check("busy_in_game", 32'(busy), 1);
        play_round(3, -1, 5'd7, 8'd3, 10'd7, 20);
        check("round_after_r0", 32'(round), 1);
        check("ucnt_cleared", 32'(user_count), 0);
        play_round(0, 2, 5'd31, 8'd0, 10'd38, 3);
        check("g1_done", 32'(done), 1);
        check("g1_busy", 32'(busy), 0);
        check("g1_round_hold", 32'(round), 1);
        repeat (3) @(negedge Clk100M);
        check("g1_pen_hold", 32'(total_penalty), 38);

        // Game 2: two rounds of 31, coincident press+submit in round 1.
        pulse_go();
        check("g2_restart_pen", 32'(total_penalty), 0);
        check("g2_restart_round", 32'(round), 0);
        check("g2_restart_ucnt", 32'(user_count), 0);
        play_round(1, -1, 5'd31, 8'd1, 10'd31, 20);
        play_round(3, 2, 5'd31, 8'd3, 10'd62, 3);
        check("g2_done", 32'(done), 1);
        check("g2_busy", 32'(busy), 0);
        check("g2_pen", 32'(total_penalty), 62);

        // Game 3: push the running sum past the top to exercise saturation.
        pulse_go();
        check("g3_restart_pen", 32'(total_penalty), 0);
        force dut.w_pen_sum = 11'd1100;
        play_round(0, -1, 5'd31, 8'd0, 10'd1023, 20);
        release dut.w_pen_sum;
        play_round(0, 0, 5'd31, 8'd0, 10'd1023, 1);
        check("g3_done", 32'(done), 1);
        check("g3_pen_sat", 32'(total_penalty), 1023);

        // Press counter saturation on the long-window instance.
        l_go = 1'b1;
        @(negedge Clk100M);
        l_go = 1'b0;
        check("long_show", 32'(l_show), 1);
        k = 0;
        while (l_show === 1'b1 && k < 100) begin
            k++;
            @(negedge Clk100M);
        end
        for (int i = 0; i < 300; i++) begin
            l_btn    = 1'b1;
            l_submit = (i == 299);
            @(negedge Clk100M);
        end
        l_btn = 1'b0; l_submit = 1'b0;
        check("long_start", 32'(l_start), 1);
        check("long_ucnt_sat", 32'(l_count), 255);
        k = 0;
        while (l_done !== 1'b1 && k < 50) begin
            k++;
            @(negedge Clk100M);
        end
        check("long_done", 32'(l_done), 1);

        // Reset while score_start is high.
        pulse_go();
        k = 0;
        while (score_start !== 1'b1 && k < 200) begin
            k++;
            @(negedge Clk100M);
        end
        check("reach_score", 32'(score_start), 1);
        Rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge Clk100M);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk100M);
        check("post_reset_idle_busy", 32'(busy), 0);
        check("post_reset_idle_show", 32'(show_symbols), 0);
        pulse_go();
        check("post_reset_go", 32'(show_symbols), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_round_sequencer
`default_nettype wire
